// File: rtl/drop_time_ctrl.sv
// Drop window controller: times a window in ticks and grants fixed-length drop enables on request edges.
// Optional DROP_COUNT_EN macro enables the granted-drop counter; otherwise drop_count is tied to zero.
module drop_time_ctrl #(
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] cfg_lim,
    input  logic        req,
    input  logic        drop_activated,
    output logic [15:0] t_act,
    output logic [15:0] t_lim,
    output logic        drop_en,
    output logic        busy,
    output logic [7:0]  drop_count
);

    // state | meaning
    // IDLE  | no window open, outputs hold last window's values
    // COUNT | window open, counting ticks, waiting for a request edge
    // HOLD  | drop_en asserted, hold timer running down
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t      state, state_nxt;
    logic        req_q;
    logic        req_edge;
    logic [7:0]  hold_cnt, hold_cnt_nxt;
    logic        act_seen, act_seen_nxt;
    logic        restart;
    logic        count_drop;
    logic [15:0] t_act_nxt, t_lim_nxt;

    assign req_edge = req & ~req_q;

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        act_seen_nxt = act_seen;
        restart      = 1'b0;
        count_drop   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    restart   = 1'b1;
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    restart   = 1'b1;
                    state_nxt = COUNT;
                end else if (req_edge) begin
                    state_nxt    = HOLD;
                    hold_cnt_nxt = HOLD_LOAD;
                    act_seen_nxt = 1'b0;
                end
            end
            HOLD: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    restart   = 1'b1;
                    state_nxt = COUNT;
                end else begin
                    act_seen_nxt = act_seen | drop_activated;
                    if (hold_cnt == 8'd0) begin
                        state_nxt  = COUNT;
                        count_drop = act_seen_nxt;
                    end else begin
                        hold_cnt_nxt = hold_cnt - 8'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ticks on a stop or restart cycle are discarded so the displayed time is stable.
    always_comb begin
        t_act_nxt = t_act;
        t_lim_nxt = t_lim;
        if (restart) begin
            t_act_nxt = 16'd0;
            t_lim_nxt = cfg_lim;
        end else if (state != IDLE && !stop && tick && t_act != 16'hFFFF) begin
            t_act_nxt = t_act + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_q    <= 1'b0;
            hold_cnt <= 8'd0;
            act_seen <= 1'b0;
            t_act    <= 16'd0;
            t_lim    <= 16'd0;
            drop_en  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            req_q    <= req;
            hold_cnt <= hold_cnt_nxt;
            act_seen <= act_seen_nxt;
            t_act    <= t_act_nxt;
            t_lim    <= t_lim_nxt;
            drop_en  <= (state_nxt == HOLD);
            busy     <= (state_nxt != IDLE);
        end
    end

`ifdef DROP_COUNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 8'd0;
        end else if (restart) begin
            drop_cnt_q <= 8'd0;
        end else if (count_drop && drop_cnt_q != 8'hFF) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    logic unused_count_drop;
    assign unused_count_drop = count_drop;
    assign drop_count        = 8'd0;
`endif

endmodule

// File: tb/tb_drop_time_ctrl.sv
// Self-checking bench for drop_time_ctrl: directed scenarios plus randomized traffic against a window model.
module tb_drop_time_ctrl;

    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0, start = 1'b0, stop = 1'b0, req = 1'b0, drop_activated = 1'b0;
    logic [15:0] cfg_lim = 16'd0;
    logic [15:0] t_act, t_lim;
    logic        drop_en, busy;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    drop_time_ctrl #(.HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop),
        .cfg_lim(cfg_lim), .req(req), .drop_activated(drop_activated),
        .t_act(t_act), .t_lim(t_lim), .drop_en(drop_en), .busy(busy),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int open;
        int hold_left;
        int seen;
        int t_act;
        int t_lim;
        int cnt;
        int req_prev;
    } mstate_t;

    mstate_t m;

    // Window model: open flag, remaining enable cycles, time and drop tallies.
    function automatic mstate_t model_step(mstate_t s, bit st, bit sp, bit tk, bit rq, bit da, int lim);
        mstate_t n = s;
        bit edge_seen = rq && (s.req_prev == 0);
        n.req_prev = rq;
        if (s.open == 0 || (!sp && st)) begin
            if (st) begin
                n.open = 1; n.t_act = 0; n.t_lim = lim; n.cnt = 0; n.hold_left = 0;
            end
        end else if (sp) begin
            n.open = 0; n.hold_left = 0;
        end else begin
            if (tk && s.t_act < 65535) n.t_act = s.t_act + 1;
            if (s.hold_left > 0) begin
                if (da) n.seen = 1;
                n.hold_left = s.hold_left - 1;
`ifdef DROP_COUNT_EN
                if (n.hold_left == 0 && n.seen != 0 && s.cnt < 255) n.cnt = s.cnt + 1;
`endif
            end else if (edge_seen) begin
                n.hold_left = HOLD; n.seen = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{default: 0};
        else        m <= model_step(m, start, stop, tick, req, drop_activated, int'(cfg_lim));
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("m_t_act", int'(t_act), m.t_act);
            check("m_t_lim", int'(t_lim), m.t_lim);
            check("m_drop_en", int'(drop_en), (m.hold_left > 0) ? 1 : 0);
            check("m_busy", int'(busy), m.open);
            check("m_drop_count", int'(drop_count), m.cnt);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [15:0] lim);
        cfg_lim = lim; start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        int exp_cnt;
        step(2);
        check("rst_t_act", int'(t_act), 0);
        check("rst_drop_en", int'(drop_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_drop_count", int'(drop_count), 0);
        rst_n = 1'b1;
        step(1);
        chk_en = 1'b1;

        // start with limit 100 plus a same-cycle tick that must be ignored
        tick = 1'b1;
        pulse_start(16'd100);
        tick = 1'b0;
        check("start_t_act0", int'(t_act), 0);
        tick = 1'b1; step(5); tick = 1'b0;
        check("lit_t_lim", int'(t_lim), 100);
        check("lit_t_act", int'(t_act), 5);
        check("lit_busy", int'(busy), 1);
        check("lit_drop_en", int'(drop_en), 0);

        // request edge: drop_en high for HOLD cycles, second edge in cycle 3 ignored
        req = 1'b1; step(1);
        for (int i = 0; i < HOLD; i++) begin
            check("hold_drop_en_hi", int'(drop_en), 1);
            if (i == 1) req = 1'b0;
            if (i == 2) req = 1'b1;
            drop_activated = (i == 4);
            step(1);
        end
        drop_activated = 1'b0;
        check("hold_drop_en_lo", int'(drop_en), 0);
`ifdef DROP_COUNT_EN
        exp_cnt = 1;
`else
        exp_cnt = 0;
`endif
        check("lit_drop_count1", int'(drop_count), exp_cnt);
        step(3);
        check("no_queued_edge", int'(drop_en), 0);
        req = 1'b0; step(1); req = 1'b1; step(HOLD + 2);
        check("lit_drop_count_keep", int'(drop_count), exp_cnt);
        req = 1'b0;

        // saturation of t_act
        pulse_start(16'd0);
        check("lim_zero", int'(t_lim), 0);
        tick = 1'b1; step(65534);
        check("lit_fffe", int'(t_act), 65534);
        step(3); tick = 1'b0;
        check("lit_ffff", int'(t_act), 65535);

        // stop and start together: stop wins
        cfg_lim = 16'd5; stop = 1'b1; start = 1'b1; tick = 1'b1;
        step(1);
        stop = 1'b0; start = 1'b0; tick = 1'b0;
        check("stopstart_busy", int'(busy), 0);
        check("stopstart_t_act", int'(t_act), 65535);
        check("stopstart_t_lim", int'(t_lim), 0);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            start          = ($urandom_range(0, 39) == 0);
            stop           = ($urandom_range(0, 59) == 0);
            tick           = $urandom_range(0, 1);
            drop_activated = ($urandom_range(0, 4) == 0);
            cfg_lim        = 16'($urandom);
            if ($urandom_range(0, 5) == 0) req = ~req;
            step(1);
        end
        start = 1'b0; stop = 1'b0; tick = 1'b0; drop_activated = 1'b0; req = 1'b0;

        // async reset in the middle of a hold, checked before any clock edge
        pulse_start(16'd7);
        step(1);
        req = 1'b1; step(3);
        check("pre_rst_drop_en", int'(drop_en), 1);
        chk_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("async_drop_en", int'(drop_en), 0);
        check("async_busy", int'(busy), 0);
        check("async_t_lim", int'(t_lim), 0);
        step(1);
        rst_n = 1'b1;
        step(2);
        check("post_rst_busy", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
